// File: rtl/ope_median_edge_pkg.sv
// ---------------------------------------------------------------------------
// ope_median_edge_pkg
//   Shared constants for the median/edge operation stage: tag encodings,
//   pixel width, the end-to-end pipeline latency and the run-time modes.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package ope_median_edge_pkg;

  localparam int TAG_WIDTH = 2;
  localparam int PIX_WIDTH = 8;

  localparam logic [TAG_WIDTH-1:0] INVALID_TAG  = 2'd0;
  localparam logic [TAG_WIDTH-1:0] DATA_TAG0    = 2'd1;
  localparam logic [TAG_WIDTH-1:0] DATA_TAG1    = 2'd2;
  localparam logic [TAG_WIDTH-1:0] DATA_END_TAG = 2'd3;

  // Input edge n reaches the output register on edge n+LATENCY-1.
  localparam int LATENCY = 4;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'd0,
    MODE_MED      = 2'd1,
    MODE_MEDSOBEL = 2'd2,
    MODE_SOBEL    = 2'd3
  } mode_e;

  function automatic logic is_data_tag(input logic [TAG_WIDTH-1:0] t);
    return (t == DATA_TAG0) || (t == DATA_TAG1);
  endfunction

endpackage

// File: rtl/ope_median_edge_col_median.sv
// ---------------------------------------------------------------------------
// ope_median_edge_col_median
//   Registered median of LEN pixels (LEN odd) using an odd-even
//   transposition sort network. Latency 1.
//   Ports:
//     clk      in  clock, rising edge
//     rst      in  asynchronous active-low reset
//     refresh  in  synchronous clear, active-high
//     pix_in   in  LEN pixels, pixel k at [k*PIX_WIDTH +: PIX_WIDTH]
//     med_out  out registered median
// ---------------------------------------------------------------------------
module ope_median_edge_col_median #(
  parameter int PIX_WIDTH = 8,
  parameter int LEN       = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     refresh,
  input  logic [LEN*PIX_WIDTH-1:0] pix_in,
  output logic [PIX_WIDTH-1:0]     med_out
);

  logic [PIX_WIDTH-1:0] med_d, med_q;

  always_comb begin
    logic [PIX_WIDTH-1:0] v [LEN];
    logic [PIX_WIDTH-1:0] tmp;
    tmp = '0;
    for (int k = 0; k < LEN; k++) begin
      v[k] = pix_in[k*PIX_WIDTH +: PIX_WIDTH];
    end
    // LEN rounds of alternating even/odd compare-exchange fully sort LEN items.
    for (int s = 0; s < LEN; s++) begin
      for (int i = s % 2; i < LEN - 1; i += 2) begin
        if (v[i] > v[i+1]) begin
          tmp    = v[i];
          v[i]   = v[i+1];
          v[i+1] = tmp;
        end
      end
    end
    med_d = refresh ? '0 : v[LEN/2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) med_q <= '0;
    else      med_q <= med_d;
  end

  assign med_out = med_q;

endmodule

// File: rtl/ope_median_edge.sv
// ---------------------------------------------------------------------------
// ope_median_edge
//   Column-median + Sobel operation stage. Column 0 of the tagged window is
//   reduced to three MED_LEN-row medians that feed a 3x3 median-of-median
//   window; a parallel raw window tracks rows c-1..c+1. The output is the
//   delayed centre pixel, the window median, or a Sobel magnitude, selected
//   by a mode latched on refresh. Fixed 4-stage latency in every mode.
//   Ports:
//     clk        in  clock, rising edge
//     rst        in  asynchronous active-low reset
//     refresh    in  synchronous frame-start clear (also latches mode)
//     mode       in  0 pass centre, 1 median, 2 median+Sobel, 3 raw Sobel
//     data_bus   in  OPE_WIDTH x OPE_WIDTH tagged window
//     out        out {tag, pixel}
//     frame_done out sticky, set the cycle after DATA_END_TAG is emitted
//     pix_count  out DATA_TAG0/DATA_TAG1 outputs emitted this frame
// ---------------------------------------------------------------------------
module ope_median_edge
  import ope_median_edge_pkg::*;
#(
  parameter int OPE_WIDTH  = 9,
  parameter int MED_LEN    = 7,
  parameter int GRAD_SHIFT = 0,
  parameter int CNT_WIDTH  = 20,
  parameter int DATA_WIDTH = PIX_WIDTH + TAG_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  refresh,
  input  logic [1:0]                            mode,
  input  logic [DATA_WIDTH*OPE_WIDTH**2-1:0]    data_bus,
  output logic [DATA_WIDTH-1:0]                 out,
  output logic                                  frame_done,
  output logic [CNT_WIDTH-1:0]                  pix_count
);

  localparam int C  = OPE_WIDTH / 2;
  localparam int O  = (OPE_WIDTH - MED_LEN - 2) / 2;
  localparam int SW = PIX_WIDTH + 3;  // holds 4*max pixel, signed
  localparam logic [PIX_WIDTH-1:0] PIX_MAX = '1;

  // Only column 0 and the centre tag are consumed.
  logic data_bus_unused;
  assign data_bus_unused = ^data_bus;

  // S1
  logic [PIX_WIDTH-1:0] col_d [OPE_WIDTH];
  logic [PIX_WIDTH-1:0] col_q [OPE_WIDTH];
  logic [PIX_WIDTH-1:0] ctr_d, ctr_q;
  // S2
  logic [PIX_WIDTH-1:0] med [3];
  logic [PIX_WIDTH-1:0] raw2_d [3];
  logic [PIX_WIDTH-1:0] raw2_q [3];
  logic [PIX_WIDTH-1:0] ctr2_d, ctr2_q;
  // S3: [row][age], age 0 is the newest column
  logic [PIX_WIDTH-1:0] w_d   [3][3];
  logic [PIX_WIDTH-1:0] w_q   [3][3];
  logic [PIX_WIDTH-1:0] raw_d [3][3];
  logic [PIX_WIDTH-1:0] raw_q [3][3];
  logic [PIX_WIDTH-1:0] ctr3_d, ctr3_q;
  // Tag delay; the output register supplies the final stage.
  logic [TAG_WIDTH-1:0] tag_d [LATENCY-1];
  logic [TAG_WIDTH-1:0] tag_q [LATENCY-1];
  // S4 and status
  logic [DATA_WIDTH-1:0] out_d, out_q;
  logic                  frame_done_d, frame_done_q;
  logic [CNT_WIDTH-1:0]  pix_count_d, pix_count_q;
  mode_e                 mode_d, mode_q;

  logic [PIX_WIDTH-1:0] res_pix;
  logic [TAG_WIDTH-1:0] out_tag;

  for (genvar g = 0; g < 3; g++) begin : g_med
    logic [MED_LEN*PIX_WIDTH-1:0] grp;
    for (genvar k = 0; k < MED_LEN; k++) begin : g_pack
      assign grp[k*PIX_WIDTH +: PIX_WIDTH] = col_q[O+g+k];
    end
    ope_median_edge_col_median #(
      .PIX_WIDTH (PIX_WIDTH),
      .LEN       (MED_LEN)
    ) u_col_median (
      .clk     (clk),
      .rst     (rst),
      .refresh (refresh),
      .pix_in  (grp),
      .med_out (med[g])
    );
  end

  function automatic logic [SW-1:0] wsum(input logic [PIX_WIDTH-1:0] a,
                                         input logic [PIX_WIDTH-1:0] b,
                                         input logic [PIX_WIDTH-1:0] c);
    return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
  endfunction

  // p[row][age]: age 0 is the left kernel column, age 2 the right one.
  function automatic logic [PIX_WIDTH-1:0] sobel_mag(input logic [PIX_WIDTH-1:0] p [3][3]);
    logic signed [SW-1:0] gx, gy;
    logic [SW-1:0] ax, ay, mag, shf;
    gx  = $signed(wsum(p[0][0], p[1][0], p[2][0])) - $signed(wsum(p[0][2], p[1][2], p[2][2]));
    gy  = $signed(wsum(p[0][0], p[0][1], p[0][2])) - $signed(wsum(p[2][0], p[2][1], p[2][2]));
    ax  = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay  = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag = ax + ay;
    shf = mag >> GRAD_SHIFT;
    return (shf > SW'(PIX_MAX)) ? PIX_MAX : shf[PIX_WIDTH-1:0];
  endfunction

  always_comb begin
    for (int y = 0; y < OPE_WIDTH; y++) begin
      col_d[y] = data_bus[(y*OPE_WIDTH)*DATA_WIDTH +: PIX_WIDTH];
    end
    ctr_d    = data_bus[(C*OPE_WIDTH)*DATA_WIDTH +: PIX_WIDTH];
    tag_d[0] = data_bus[(C*OPE_WIDTH+C)*DATA_WIDTH+PIX_WIDTH +: TAG_WIDTH];
    for (int k = 1; k < LATENCY - 1; k++) begin
      tag_d[k] = tag_q[k-1];
    end

    ctr2_d = ctr_q;
    ctr3_d = ctr2_q;
    for (int r = 0; r < 3; r++) begin
      raw2_d[r]   = col_q[C-1+r];
      w_d[r][0]   = med[r];
      w_d[r][1]   = w_q[r][0];
      w_d[r][2]   = w_q[r][1];
      raw_d[r][0] = raw2_q[r];
      raw_d[r][1] = raw_q[r][0];
      raw_d[r][2] = raw_q[r][1];
    end

    case (mode_q)
      MODE_PASS:     res_pix = ctr3_q;
      MODE_MED:      res_pix = w_q[1][1];
      MODE_MEDSOBEL: res_pix = sobel_mag(w_q);
      MODE_SOBEL:    res_pix = sobel_mag(raw_q);
      default:       res_pix = '0;
    endcase

    out_tag      = tag_q[LATENCY-2];
    out_d        = {out_tag, (out_tag == INVALID_TAG) ? '0 : res_pix};
    pix_count_d  = pix_count_q + CNT_WIDTH'(is_data_tag(out_tag));
    frame_done_d = frame_done_q | (out_q[DATA_WIDTH-1 -: TAG_WIDTH] == DATA_END_TAG);
    mode_d       = mode_q;

    // Frame start: same clear as reset, data in this cycle is dropped.
    if (refresh) begin
      for (int y = 0; y < OPE_WIDTH; y++) col_d[y] = '0;
      for (int k = 0; k < LATENCY - 1; k++) tag_d[k] = INVALID_TAG;
      for (int r = 0; r < 3; r++) begin
        raw2_d[r] = '0;
        for (int a = 0; a < 3; a++) begin
          w_d[r][a]   = '0;
          raw_d[r][a] = '0;
        end
      end
      ctr_d        = '0;
      ctr2_d       = '0;
      ctr3_d       = '0;
      out_d        = '0;
      pix_count_d  = '0;
      frame_done_d = 1'b0;
      mode_d       = mode_e'(mode);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int y = 0; y < OPE_WIDTH; y++) col_q[y] <= '0;
      for (int k = 0; k < LATENCY - 1; k++) tag_q[k] <= INVALID_TAG;
      for (int r = 0; r < 3; r++) begin
        raw2_q[r] <= '0;
        for (int a = 0; a < 3; a++) begin
          w_q[r][a]   <= '0;
          raw_q[r][a] <= '0;
        end
      end
      ctr_q        <= '0;
      ctr2_q       <= '0;
      ctr3_q       <= '0;
      out_q        <= '0;
      pix_count_q  <= '0;
      frame_done_q <= 1'b0;
      mode_q       <= MODE_PASS;
    end else begin
      col_q        <= col_d;
      tag_q        <= tag_d;
      raw2_q       <= raw2_d;
      w_q          <= w_d;
      raw_q        <= raw_d;
      ctr_q        <= ctr_d;
      ctr2_q       <= ctr2_d;
      ctr3_q       <= ctr3_d;
      out_q        <= out_d;
      pix_count_q  <= pix_count_d;
      frame_done_q <= frame_done_d;
      mode_q       <= mode_d;
    end
  end

  assign out        = out_q;
  assign frame_done = frame_done_q;
  assign pix_count  = pix_count_q;

endmodule

// File: tb/tb_ope_median_edge.sv
// ---------------------------------------------------------------------------
// tb_ope_median_edge
//   Directed bench for ope_median_edge. Two instances share all inputs:
//   dut uses GRAD_SHIFT=0, dut_s3 uses GRAD_SHIFT=3. Every window pixel in
//   row y carries col_v[y] and the same tag. Inputs change 1 ns after the
//   rising edge, outputs are read at that same point.
// ---------------------------------------------------------------------------
module tb_ope_median_edge;
  import ope_median_edge_pkg::*;

  localparam int OPE  = 9;
  localparam int DW   = PIX_WIDTH + TAG_WIDTH;
  localparam int BUSW = DW * OPE * OPE;
  localparam int CW   = 20;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic            refresh;
  logic [1:0]      mode;
  logic [BUSW-1:0] data_bus;
  logic [DW-1:0]   out, s3_out;
  logic            frame_done, s3_frame_done;
  logic [CW-1:0]   pix_count, s3_pix_count;

  always #5 clk = ~clk;

  ope_median_edge #(.GRAD_SHIFT(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .refresh    (refresh),
    .mode       (mode),
    .data_bus   (data_bus),
    .out        (out),
    .frame_done (frame_done),
    .pix_count  (pix_count)
  );

  ope_median_edge #(.GRAD_SHIFT(3)) dut_s3 (
    .clk        (clk),
    .rst        (rst),
    .refresh    (refresh),
    .mode       (mode),
    .data_bus   (data_bus),
    .out        (s3_out),
    .frame_done (s3_frame_done),
    .pix_count  (s3_pix_count)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [7:0] p);
    return 32'({t, p});
  endfunction

  // ---------------- driver tasks ----------------
  logic [7:0] col_v [OPE];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_col(input logic [7:0] v);
    for (int i = 0; i < OPE; i++) col_v[i] = v;
  endtask

  task automatic apply(input logic [1:0] tag);
    for (int y = 0; y < OPE; y++)
      for (int x = 0; x < OPE; x++)
        data_bus[(y*OPE+x)*DW +: DW] = {tag, col_v[y]};
  endtask

  // One refresh edge; whatever sits on data_bus during it is dropped.
  task automatic do_refresh(input logic [1:0] m);
    mode    = m;
    refresh = 1'b1;
    tick(1);
    refresh = 1'b0;
  endtask

  // Zero frame, one pulse column at rows lo..hi = 200, then zeros; reads the
  // output on the edge where the pulse sits in the newest window column.
  task automatic run_pulse(input string name, input logic [1:0] m, input int lo, input int hi,
                           input logic [7:0] exp0, input logic [7:0] exp3);
    do_refresh(m);
    fill_col(8'd0);
    apply(DATA_TAG0);
    tick(5);
    for (int i = lo; i <= hi; i++) col_v[i] = 8'd200;
    apply(DATA_TAG0);
    tick(1);
    fill_col(8'd0);
    apply(DATA_TAG0);
    tick(3);
    check_eq({name, "_shift0"}, 32'(out),    mk(DATA_TAG0, exp0));
    check_eq({name, "_shift3"}, 32'(s3_out), mk(DATA_TAG0, exp3));
  endtask

  logic [1:0] seq [6];

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b0;
    refresh = 1'b0;
    mode    = 2'd0;
    fill_col(8'd0);
    apply(INVALID_TAG);
    tick(2);
    check_eq("reset_out",        32'(out),        32'd0);
    check_eq("reset_frame_done", 32'(frame_done), 32'd0);
    check_eq("reset_pix_count",  32'(pix_count),  32'd0);
    rst = 1'b1;
    tick(1);

    // Constant 100 window. The refresh-edge input is dropped, so the first
    // valid output appears on the 4th edge after refresh, not the 3rd.
    fill_col(8'd100);
    apply(DATA_TAG0);
    do_refresh(MODE_PASS);
    tick(3);
    check_eq("refresh_drop_out", 32'(out), mk(INVALID_TAG, 8'd0));
    tick(1);
    check_eq("const_pass", 32'(out), mk(DATA_TAG0, 8'd100));
    do_refresh(MODE_MED);
    tick(6);
    check_eq("const_med", 32'(out), mk(DATA_TAG0, 8'd100));
    // Half-filled window: only the newest column is 100 -> |Gx|=400.
    do_refresh(MODE_MEDSOBEL);
    tick(4);
    check_eq("fill_medsobel_s0", 32'(out),    mk(DATA_TAG0, 8'd255));
    check_eq("fill_medsobel_s3", 32'(s3_out), mk(DATA_TAG0, 8'd50));
    tick(2);
    check_eq("const_medsobel", 32'(out), mk(DATA_TAG0, 8'd0));

    // Step edge: whole column 200 -> |Gx|=800.
    run_pulse("step_medsobel", MODE_MEDSOBEL, 0, 8, 8'd255, 8'd100);
    tick(1);
    check_eq("step_mid_s0", 32'(out),    mk(DATA_TAG0, 8'd0));
    check_eq("step_mid_s3", 32'(s3_out), mk(DATA_TAG0, 8'd0));
    tick(1);
    check_eq("step_old_s0", 32'(out),    mk(DATA_TAG0, 8'd255));
    check_eq("step_old_s3", 32'(s3_out), mk(DATA_TAG0, 8'd100));
    // Rows 3..5 only: medians stay 0, raw centre rows see the full edge.
    run_pulse("band_sobel",    MODE_SOBEL,    3, 5, 8'd255, 8'd100);
    run_pulse("band_medsobel", MODE_MEDSOBEL, 3, 5, 8'd0,   8'd0);

    // Outlier 255 at the centre row of a constant-10 column.
    fill_col(8'd10);
    col_v[4] = 8'd255;
    apply(DATA_TAG0);
    do_refresh(MODE_MED);
    tick(6);
    check_eq("outlier_med", 32'(out), mk(DATA_TAG0, 8'd10));
    do_refresh(MODE_PASS);
    tick(6);
    check_eq("outlier_pass", 32'(out), mk(DATA_TAG0, 8'd255));
    mode = MODE_MED;  // no refresh -> must be ignored
    tick(6);
    check_eq("mode_ignored", 32'(out), mk(DATA_TAG0, 8'd255));

    // Frame: 5 valid tags then END.
    seq[0] = DATA_TAG0; seq[1] = DATA_TAG0; seq[2] = DATA_TAG0;
    seq[3] = DATA_TAG1; seq[4] = DATA_TAG1; seq[5] = DATA_END_TAG;
    fill_col(8'd50);
    do_refresh(MODE_PASS);
    for (int i = 0; i < 6; i++) begin
      apply(seq[i]);
      tick(1);
    end
    apply(INVALID_TAG);
    tick(2);
    check_eq("frame_count_pre_end", 32'(pix_count),  32'd5);
    check_eq("frame_done_pre_end",  32'(frame_done), 32'd0);
    tick(1);
    check_eq("end_tag_out",      32'(out[DW-1 -: TAG_WIDTH]), 32'(DATA_END_TAG));
    check_eq("end_frame_done",   32'(frame_done),             32'd0);
    check_eq("end_pix_count",    32'(pix_count),              32'd5);
    tick(1);
    check_eq("done_rise",        32'(frame_done),    32'd1);
    check_eq("done_rise_s3",     32'(s3_frame_done), 32'd1);
    check_eq("done_pix_count",   32'(pix_count),     32'd5);
    check_eq("done_pix_count_s3", 32'(s3_pix_count), 32'd5);
    check_eq("invalid_forced_0", 32'(out),           mk(INVALID_TAG, 8'd0));
    do_refresh(MODE_PASS);
    check_eq("refresh_frame_done", 32'(frame_done), 32'd0);
    check_eq("refresh_pix_count",  32'(pix_count),  32'd0);

    // Asynchronous reset with the pipeline full.
    fill_col(8'd77);
    apply(DATA_TAG0);
    do_refresh(MODE_PASS);
    tick(8);
    check_eq("full_out",       32'(out),       mk(DATA_TAG0, 8'd77));
    check_eq("full_pix_count", 32'(pix_count), 32'd5);
    #3;
    rst = 1'b0;
    #1;
    check_eq("async_rst_out",        32'(out),        32'd0);
    check_eq("async_rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("async_rst_pix_count",  32'(pix_count),  32'd0);
    tick(2);
    check_eq("rst_held_out", 32'(out), 32'd0);
    rst = 1'b1;
    tick(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
